regfile_port_ctrl: RTL and testbench

- Initiator-side controller that drives the 16x32 register file's single write port and two read ports on behalf of the pipeline.
- Accepts operand-fetch requests and writeback requests, each on its own valid/ready channel.
- Arbitrates them against the file's rule that a write cycle suppresses the read update.
- Returns latched operand pairs on a valid/ready output channel, with a starvation guard so reads always make progress.

---
 rtl/regfile_port_ctrl.sv | 140 ++++++++++++++
 tb/tb_regfile_port_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_ctrl.sv
// Register file port controller: drives the single write port and the two
// read ports of a 16x32 register file on behalf of the pipeline.
// Writebacks win the write port combinationally; operand fetches are issued
// only in cycles without a write (a write cycle suppresses the file's read
// update). A streak counter forces a write-free cycle so that a pending
// fetch cannot be starved indefinitely.
// Optional feature macro: REGFILE_CTRL_BYPASS_EN.
// When it is defined, writebacks that land during WAIT/HOLD are forwarded
// into the latched operands.
module regfile_port_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic                  rf_write,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_addr_a,
    output logic [ADDR_WIDTH-1:0] rf_read_addr_b,
    input  logic [DATA_WIDTH-1:0] rf_read_data_a,
    input  logic [DATA_WIDTH-1:0] rf_read_data_b
);

    // Counter only needs to reach STARVE_LIMIT; keep at least one bit.
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    op_valid_q;
    logic [DATA_WIDTH-1:0]   op_a_q;
    logic [DATA_WIDTH-1:0]   op_b_q;
    logic [ADDR_WIDTH-1:0]   rs1_q;
    logic [ADDR_WIDTH-1:0]   rs2_q;
    logic [CW-1:0]           streak_q;

    logic guard_d;
    logic wb_fire_d;
    logic rf_write_d;
    logic req_fire_d;

    // Handshake decode: guard cycle blocks writeback, a real write blocks the fetch.
    always_comb begin
        guard_d    = (STARVE_LIMIT > 0) && (streak_q == CW'(STARVE_LIMIT));
        wb_fire_d  = wb_valid && !guard_d;
        rf_write_d = wb_fire_d && (wb_addr != '0);
        req_fire_d = req_valid && (state_q == IDLE) && !rf_write_d;
    end

    assign wb_ready       = !guard_d;
    assign rf_write       = rf_write_d;
    assign rf_write_addr  = wb_addr;
    assign rf_write_data  = wb_data;
    assign req_ready      = (state_q == IDLE) && !rf_write_d;
    // In IDLE the live request addresses go straight to the file so it can
    // sample them on the accepting edge; afterwards the latched copy is held.
    assign rf_read_addr_a = (state_q == IDLE) ? req_rs1 : rs1_q;
    assign rf_read_addr_b = (state_q == IDLE) ? req_rs2 : rs2_q;
    assign op_valid       = op_valid_q;
    assign op_a           = op_a_q;
    assign op_b           = op_b_q;

    // Fetch FSM, operand registers and starvation streak counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_valid_q <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            streak_q   <= '0;
        end else begin
            // Streak counts IDLE cycles where a pending fetch lost to a write.
            if (req_fire_d || !req_valid || guard_d) begin
                streak_q <= '0;
            end else if ((STARVE_LIMIT > 0) && (state_q == IDLE) && rf_write_d) begin
                streak_q <= streak_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (req_fire_d) begin
                        rs1_q   <= req_rs1;
                        rs2_q   <= req_rs2;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    op_a_q     <= rf_read_data_a;
                    op_b_q     <= rf_read_data_b;
                    op_valid_q <= 1'b1;
                    state_q    <= HOLD;
                end
                HOLD: begin
                    if (op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    op_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase

`ifdef REGFILE_CTRL_BYPASS_EN
            // Forward writebacks into the operands; later assignment overrides
            // the WAIT capture so operands never go stale against the file.
            if ((state_q == WAIT || state_q == HOLD) && rf_write_d) begin
                if (wb_addr == rs1_q) begin
                    op_a_q <= wb_data;
                end
                if (wb_addr == rs2_q) begin
                    op_b_q <= wb_data;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed testbench for regfile_port_ctrl with a behavioural 16x32 register
// file (registered read, read update suppressed on write cycles, r0 reads 0).
module tb_regfile_port_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_rs1, req_rs2;
    logic          wb_valid, wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          op_valid, op_ready;
    logic [DW-1:0] op_a, op_b;
    logic          rf_write;
    logic [AW-1:0] rf_write_addr, rf_read_addr_a, rf_read_addr_b;
    logic [DW-1:0] rf_write_data, rf_read_data_a, rf_read_data_b;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b),
        .rf_write(rf_write), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
        .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b)
    );

    // Register file model
    logic [DW-1:0] mem [16];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            rf_read_data_a <= '0;
            rf_read_data_b <= '0;
        end else if (rf_write) begin
            if (rf_write_addr != 0) mem[rf_write_addr] <= rf_write_data;
        end else begin
            rf_read_data_a <= (rf_read_addr_a == 0) ? '0 : mem[rf_read_addr_a];
            rf_read_data_b <= (rf_read_addr_b == 0) ? '0 : mem[rf_read_addr_b];
        end
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 0; req_rs1 = 0; req_rs2 = 0;
        wb_valid = 0; wb_addr = 0; wb_data = 0; op_ready = 0;
        step(); step();
        reset = 1'b0;
        #1;
        checks++; if (op_valid !== 1'b0) $display("FAIL reset_op_valid: got %0b want 0", op_valid); else passed++;
        checks++; if (op_a !== 32'h0 || op_b !== 32'h0) $display("FAIL reset_ops: got %h/%h want 0/0", op_a, op_b); else passed++;
        checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready); else passed++;
        checks++; if (wb_ready !== 1'b1 || rf_write !== 1'b0) $display("FAIL reset_wb: got wb_ready=%0b rf_write=%0b want 1/0", wb_ready, rf_write); else passed++;
        $display("reset: released");
    endtask

    task automatic test_basic_fetch();
        wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
        #1;
        checks++; if (rf_write !== 1'b1 || rf_write_addr !== 4'd5 || rf_write_data !== 32'hDEADBEEF)
            $display("FAIL wb_r5_drive: got we=%0b a=%0d d=%h want 1/5/deadbeef", rf_write, rf_write_addr, rf_write_data); else passed++;
        step();
        wb_valid = 0;
        req_valid = 1; req_rs1 = 5; req_rs2 = 0; op_ready = 1;
        #1;
        checks++; if (req_ready !== 1'b1 || rf_read_addr_a !== 4'd5) $display("FAIL fetch_issue: got ready=%0b addr_a=%0d want 1/5", req_ready, rf_read_addr_a); else passed++;
        step();
        req_valid = 0; req_rs1 = 9; req_rs2 = 9;
        #1;
        checks++; if (op_valid !== 1'b0 || req_ready !== 1'b0 || rf_read_addr_a !== 4'd5)
            $display("FAIL fetch_wait: got op_valid=%0b req_ready=%0b addr_a=%0d want 0/0/5", op_valid, req_ready, rf_read_addr_a); else passed++;
        step();
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hDEADBEEF || op_b !== 32'h0)
            $display("FAIL fetch_result: got v=%0b a=%h b=%h want 1/deadbeef/0", op_valid, op_a, op_b); else passed++;
        step();
        checks++; if (op_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL fetch_return_idle: got v=%0b ready=%0b want 0/1", op_valid, req_ready); else passed++;
        $display("fetch rs1=5 rs2=0: a=%h b=%h", 32'hDEADBEEF, 32'h0);
    endtask

    task automatic test_starvation();
        op_ready = 1;
        wb_valid = 1; wb_addr = 3; wb_data = 32'hA5A5_0003;
        req_valid = 1; req_rs1 = 3; req_rs2 = 5;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0 || wb_ready !== 1'b1 || rf_write !== 1'b1)
                $display("FAIL starve_block_c%0d: got req_ready=%0b wb_ready=%0b we=%0b want 0/1/1", i, req_ready, wb_ready, rf_write); else passed++;
            step();
        end
        #1;
        checks++; if (wb_ready !== 1'b0 || rf_write !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL starve_guard_c5: got wb_ready=%0b we=%0b req_ready=%0b want 0/0/1", wb_ready, rf_write, req_ready); else passed++;
        step();
        wb_valid = 0; req_valid = 0;
        step();
        checks++; if (op_valid !== 1'b1 || op_a !== 32'hA5A5_0003 || op_b !== 32'hDEADBEEF)
            $display("FAIL starve_result: got v=%0b a=%h b=%h want 1/a5a50003/deadbeef", op_valid, op_a, op_b); else passed++;
        step();
        wb_valid = 1; wb_addr = 3;
        #1;
        checks++; if (wb_ready !== 1'b1) $display("FAIL starve_cleared: got wb_ready=%0b want 1", wb_ready); else passed++;
        wb_valid = 0;
        $display("starvation: fetch accepted on guard cycle 5");
    endtask

    task automatic test_r0_write();
        op_ready = 1;
        wb_valid = 1; wb_addr = 0; wb_data = 32'h1234;
        req_valid = 1; req_rs1 = 0; req_rs2 = 5;
        #1;
        checks++; if (wb_ready !== 1'b1 || rf_write !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL r0_write: got wb_ready=%0b we=%0b req_ready=%0b want 1/0/1", wb_ready, rf_write, req_ready); else passed++;
        step();
        wb_valid = 0; req_valid = 0;
        step();
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h0 || op_b !== 32'hDEADBEEF)
            $display("FAIL r0_read: got v=%0b a=%h b=%h want 1/0/deadbeef", op_valid, op_a, op_b); else passed++;
        step();
        $display("r0 write dropped, read r0 = 0");
    endtask

    task automatic test_hold_stall();
        op_ready = 0;
        req_valid = 1; req_rs1 = 5; req_rs2 = 3;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (op_valid !== 1'b1 || op_a !== 32'hDEADBEEF || op_b !== 32'hA5A5_0003 || req_ready !== 1'b0)
                $display("FAIL hold_stall_c%0d: got v=%0b a=%h b=%h rdy=%0b want 1/deadbeef/a5a50003/0", i, op_valid, op_a, op_b, req_ready); else passed++;
            step();
        end
        op_ready = 1; req_valid = 0;
        #1;
        checks++; if (op_valid !== 1'b1) $display("FAIL hold_release: got v=%0b want 1", op_valid); else passed++;
        step();
        checks++; if (op_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL hold_done: got v=%0b rdy=%0b want 0/1", op_valid, req_ready); else passed++;
        $display("hold stall 5 cycles then consumed");
    endtask

    task automatic test_reset_in_wait();
        op_ready = 1;
        req_valid = 1; req_rs1 = 5; req_rs2 = 3;
        step();
        req_valid = 0;
        reset = 1;
        step();
        reset = 0;
        #1;
        checks++; if (op_valid !== 1'b0 || op_a !== 32'h0 || op_b !== 32'h0 || req_ready !== 1'b1)
            $display("FAIL reset_in_wait: got v=%0b a=%h b=%h rdy=%0b want 0/0/0/1", op_valid, op_a, op_b, req_ready); else passed++;
        step();
        checks++; if (op_valid !== 1'b0) $display("FAIL reset_in_wait_flush: got v=%0b want 0", op_valid); else passed++;
        $display("reset in WAIT: fetch discarded");
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_v;
`ifdef REGFILE_CTRL_BYPASS_EN
        exp_v = 32'h55;
`else
        exp_v = 32'h1;
`endif
        op_ready = 0;
        wb_valid = 1; wb_addr = 7; wb_data = 32'h1;
        step();
        wb_valid = 0;
        req_valid = 1; req_rs1 = 7; req_rs2 = 7;
        step();
        req_valid = 0;
        step();
        checks++; if (op_valid !== 1'b1 || op_a !== 32'h1 || op_b !== 32'h1)
            $display("FAIL bypass_pre: got v=%0b a=%h b=%h want 1/1/1", op_valid, op_a, op_b); else passed++;
        wb_valid = 1; wb_addr = 7; wb_data = 32'h55;
        step();
        wb_valid = 0;
        checks++; if (op_a !== exp_v || op_b !== exp_v)
            $display("FAIL bypass_hold: got a=%h b=%h want %h/%h", op_a, op_b, exp_v, exp_v); else passed++;
        op_ready = 1;
        step();
        checks++; if (op_valid !== 1'b0) $display("FAIL bypass_done: got v=%0b want 0", op_valid); else passed++;
        $display("fetch r7 with write 0x55 in HOLD: operands=%h", exp_v);
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_starvation();
        test_r0_write();
        test_hold_stall();
        test_reset_in_wait();
        test_bypass();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
